// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix sense/drive lines plus the key-event outputs
// consumed by the calculator controller.
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       num;
  logic       OP;
  logic       C;
  logic       EQ;
  logic [3:0] key_val;
  logic [1:0] op_code;
  logic       key_busy;

  modport master (
    input  col_n,
    output row_n, num, OP, C, EQ, key_val, op_code, key_busy
  );

  modport slave (
    output col_n,
    input  row_n, num, OP, C, EQ, key_val, op_code, key_busy
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and one-cycle key events.
// Optional auto-repeat of digit keys while held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEB_CYCLES    = 20000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int unsigned MAX_CNT = (SCAN_DIV > DEB_CYCLES) ? SCAN_DIV : DEB_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    SCAN     = 3'd0,
    DEBOUNCE = 3'd1,
    EMIT     = 3'd2,
    HOLD     = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  state_e        state_q;
  logic [3:0]    sync1_q;
  logic [3:0]    cs_q;
  logic [3:0]    pat_q;
  logic [3:0]    row_n_q;
  logic [1:0]    row_q;
  logic [1:0]    col_q;
  logic [CW-1:0] div_q;
  logic [CW-1:0] cnt_q;
  logic          num_q;
  logic          op_q;
  logic          clr_q;
  logic          eq_q;
  logic [3:0]    key_val_q;
  logic [1:0]    op_code_q;
  logic          busy_q;

  logic [3:0]    cs_low;
  logic          one_low;
  logic          all_high;
  logic [1:0]    col_enc;
  logic          is_digit;
  logic          is_op;
  logic          is_clr;
  logic          is_eq;
  logic [3:0]    digit_val;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned HW = $clog2(REPEAT_CYCLES + 1);
  logic [HW-1:0] hold_q;

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (v == {HW{1'b1}}) ? v : v + HW'(1);
  endfunction
`else
  logic unused_repeat;
  assign unused_repeat = ^32'(REPEAT_CYCLES);
`endif

  // Single-key detection on the synchronised column sense
  always_comb begin
    cs_low   = ~cs_q;
    one_low  = (cs_low != 4'd0) && ((cs_low & (cs_low - 4'd1)) == 4'd0);
    all_high = (cs_q == 4'hF);
    case (cs_low)
      4'b0010: col_enc = 2'd1;
      4'b0100: col_enc = 2'd2;
      4'b1000: col_enc = 2'd3;
      default: col_enc = 2'd0;
    endcase
  end

  // Key map decode of the latched row/column
  always_comb begin
    is_digit  = 1'b0;
    is_op     = 1'b0;
    is_clr    = 1'b0;
    is_eq     = 1'b0;
    digit_val = 4'd0;
    if (col_q == 2'd3) begin
      is_op = 1'b1;
    end else if (row_q == 2'd3) begin
      case (col_q)
        2'd0:    is_clr = 1'b1;
        2'd1:    is_digit = 1'b1;
        default: is_eq = 1'b1;
      endcase
    end else begin
      is_digit  = 1'b1;
      digit_val = 4'(row_q) * 4'd3 + 4'(col_q) + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      sync1_q   <= 4'hF;
      cs_q      <= 4'hF;
      pat_q     <= 4'hF;
      row_n_q   <= 4'b1110;
      row_q     <= 2'd0;
      col_q     <= 2'd0;
      div_q     <= '0;
      cnt_q     <= '0;
      num_q     <= 1'b0;
      op_q      <= 1'b0;
      clr_q     <= 1'b0;
      eq_q      <= 1'b0;
      key_val_q <= 4'd0;
      op_code_q <= 2'd0;
      busy_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_q    <= '0;
`endif
    end else begin
      sync1_q <= kp.col_n;
      cs_q    <= sync1_q;
      num_q   <= 1'b0;
      op_q    <= 1'b0;
      clr_q   <= 1'b0;
      eq_q    <= 1'b0;

      case (state_q)
        SCAN: begin
          if (div_q >= CW'(SCAN_DIV - 1)) begin
            div_q <= '0;
            if (one_low) begin
              pat_q   <= cs_q;
              col_q   <= col_enc;
              cnt_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              row_q   <= row_q + 2'd1;
              row_n_q <= {row_n_q[2:0], row_n_q[3]};
            end
          end else begin
            div_q <= sat_inc(div_q);
          end
        end

        DEBOUNCE: begin
          if (cs_q != pat_q) begin
            cnt_q   <= '0;
            div_q   <= '0;
            state_q <= SCAN;
          end else if (cnt_q >= CW'(DEB_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= EMIT;
            busy_q  <= 1'b1;
            num_q   <= is_digit;
            op_q    <= is_op;
            clr_q   <= is_clr;
            eq_q    <= is_eq;
            if (is_digit) key_val_q <= digit_val;
            if (is_op)    op_code_q <= row_q;
`ifdef KEYPAD_REPEAT_EN
            hold_q  <= '0;
`endif
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        EMIT: begin
          state_q <= HOLD;
`ifdef KEYPAD_REPEAT_EN
          hold_q  <= sat_inc_h(hold_q);
`endif
        end

        // The cycle that first sees all-high already counts toward release
        HOLD: begin
          if (all_high) begin
            cnt_q   <= CW'(1);
            state_q <= RELEASE;
`ifdef KEYPAD_REPEAT_EN
            hold_q  <= '0;
          end else if (is_digit) begin
            if (hold_q >= HW'(REPEAT_CYCLES - 1)) begin
              num_q  <= 1'b1;
              hold_q <= '0;
            end else begin
              hold_q <= sat_inc_h(hold_q);
            end
`endif
          end
        end

        RELEASE: begin
          if (!all_high) begin
            cnt_q <= '0;
          end else if (cnt_q >= CW'(DEB_CYCLES - 1)) begin
            cnt_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= SCAN;
            row_q   <= row_q + 2'd1;
            row_n_q <= {row_n_q[2:0], row_n_q[3]};
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        default: state_q <= SCAN;
      endcase
    end
  end

  assign kp.row_n    = row_n_q;
  assign kp.num      = num_q;
  assign kp.OP       = op_q;
  assign kp.C        = clr_q;
  assign kp.EQ       = eq_q;
  assign kp.key_val  = key_val_q;
  assign kp.op_code  = op_code_q;
  assign kp.key_busy = busy_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: directed key presses push expected events,
// a negedge monitor pops and checks every emitted pulse.
module tb_keypad_scanner;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned RP = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEB_CYCLES    (DB),
    .REPEAT_CYCLES (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  typedef struct packed {
    logic [1:0] kind;   // 0 num, 1 OP, 2 C, 3 EQ
    logic [3:0] val;
  } ev_t;

  ev_t         sb[$];
  logic [15:0] pressed;     // bit r*4+c
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_pc = 0;
  int          prev_pc = 0;

  // Passive matrix model: a pressed key pulls its column low while its row is driven
  always_comb begin
    kp.col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.row_n[r]) kp.col_n[c] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    int n;
    ev_t e;
    logic [1:0] k;
    n = int'(kp.num) + int'(kp.OP) + int'(kp.C) + int'(kp.EQ);
    if (n > 1) begin
      chk("pulse_exclusive", n, 1);
    end else if (n == 1) begin
      k = kp.num ? 2'd0 : kp.OP ? 2'd1 : kp.C ? 2'd2 : 2'd3;
      prev_pc = last_pc;
      last_pc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", int'(k), -1);
      end else begin
        e = sb.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        if (k == 2'd0) chk("key_val", int'(kp.key_val), int'(e.val));
        if (k == 2'd1) chk("op_code", int'(kp.op_code), int'(e.val));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row_n"},   int'(kp.row_n), 4'hE);
    chk({tag, "_pulses"},  int'({kp.num, kp.OP, kp.C, kp.EQ}), 0);
    chk({tag, "_busy"},    int'(kp.key_busy), 0);
    chk({tag, "_key_val"}, int'(kp.key_val), 0);
    chk({tag, "_op_code"}, int'(kp.op_code), 0);
  endtask

  task automatic wait_row(input logic [3:0] v);
    int i = 0;
    while (kp.row_n != v && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("wait_row", int'(kp.row_n), int'(v));
  endtask

  task automatic press(input int r, input int c, input int hold,
                       input logic [1:0] kind, input logic [3:0] val);
    sb.push_back('{kind: kind, val: val});
    @(negedge clk);
    pressed[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    chk("busy_while_held", int'(kp.key_busy), 1);
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("event_consumed", sb.size(), 0);
    chk("busy_after_release", int'(kp.key_busy), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_end;
    int i;
    pressed = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Idle rotation, one row per SCAN_DIV cycles
    repeat (3) @(negedge clk);
    chk("rot_dwell", int'(kp.row_n), 4'hE);
    @(negedge clk);
    chk("rot_r1", int'(kp.row_n), 4'hD);
    repeat (4) @(negedge clk);
    chk("rot_r2", int'(kp.row_n), 4'hB);
    repeat (4) @(negedge clk);
    chk("rot_r3", int'(kp.row_n), 4'h7);
    repeat (4) @(negedge clk);
    chk("rot_wrap", int'(kp.row_n), 4'hE);

    // '5' held 100 cycles; key_busy falls 8 cycles after cs goes all-high
    sb.push_back('{kind: 2'd0, val: 4'd5});
    pressed[5] = 1'b1;
    repeat (100) @(negedge clk);
    chk("five_busy_held", int'(kp.key_busy), 1);
    chk("five_consumed", sb.size(), 0);
    pressed = '0;
    repeat (9) @(negedge clk);
    chk("five_busy_before_fall", int'(kp.key_busy), 1);
    @(negedge clk);
    chk("five_busy_fall", int'(kp.key_busy), 0);
    repeat (10) @(negedge clk);

    // Operators and control keys
    press(2, 3, 60, 2'd1, 4'd2);
    chk("key_val_held", int'(kp.key_val), 5);
    press(3, 2, 60, 2'd3, 4'd0);
    press(3, 0, 60, 2'd2, 4'd0);
    chk("op_code_held", int'(kp.op_code), 2);

    // '7' bouncing every 3 cycles, then stable
    sb.push_back('{kind: 2'd0, val: 4'd7});
    for (int k = 0; k < 14; k++) begin
      pressed[8] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    pressed[8] = 1'b1;
    t_end = cyc;
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk("bounce_consumed", sb.size(), 0);
    chk("bounce_latency_window",
        int'((last_pc - t_end) >= 8 && (last_pc - t_end) <= 40), 1);
    repeat (30) @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("bounce_single", sb.size(), 0);

    // '1' and '2' together on row 0: ignored
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    repeat (60) @(negedge clk);
    chk("ghost_busy", int'(kp.key_busy), 0);
    pressed = '0;
    repeat (20) @(negedge clk);

    // Reset asserted while '9' is debouncing
    wait_row(4'hE);
    pressed[10] = 1'b1;
    wait_row(4'hB);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("mid_debounce_reset");
    pressed = '0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("after_reset_busy", int'(kp.key_busy), 0);

`ifdef KEYPAD_REPEAT_EN
    // '3' held: num at t0, t0+32, t0+64
    repeat (3) sb.push_back('{kind: 2'd0, val: 4'd3});
    pressed[2] = 1'b1;
    i = 0;
    while (sb.size() == 3 && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("repeat_first", sb.size(), 2);
    t_end = last_pc;
    repeat (70) @(negedge clk);
    pressed = '0;
    repeat (20) @(negedge clk);
    chk("repeat_all_consumed", sb.size(), 0);
    chk("repeat_second_time", prev_pc - t_end, 32);
    chk("repeat_third_time", last_pc - t_end, 64);
    press(0, 3, 70, 2'd1, 4'd0);
`endif

    repeat (10) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
